// File: rtl/load_align_unit_pkg.sv
// load_align_unit_pkg: load funct3 encodings, FSM state type and size/legality
// helpers shared by the load alignment path.
package load_align_unit_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } load_funct3_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } load_state_e;

    // Access size in bytes.
    function automatic logic [3:0] load_size(input logic [2:0] funct3);
        unique case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // LD and LWU only exist on a 64-bit datapath.
    function automatic logic load_legal(input logic [2:0] funct3,
                                        input int xlen);
        case (funct3)
            LB, LH, LW, LBU, LHU: return 1'b1;
            LD, LWU:              return (xlen == 64);
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract_extend.sv
// load_extract_extend: shifts the merged {word1, word0} down by the byte offset
// and sign/zero-extends the addressed bytes to XLEN.
// Ports: word0_i/word1_i memory words, ofs_i byte offset, funct3_i, data_o result.
module load_extract_extend
    import load_align_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              word0_i,
    input  logic [XLEN-1:0]              word1_i,
    input  logic [$clog2(XLEN/8)-1:0]    ofs_i,
    input  logic [2:0]                   funct3_i,
    output logic [XLEN-1:0]              data_o
);

    logic [XLEN-1:0] low;
    logic            fill;
    int              nbits;

    assign low = XLEN'({word1_i, word0_i} >> {ofs_i, 3'b000});

    always_comb begin
        nbits = XLEN;
        fill  = 1'b0;
        unique case (funct3_i[1:0])
            2'b00:   begin nbits = 8;    fill = low[7];      end
            2'b01:   begin nbits = 16;   fill = low[15];     end
            2'b10:   begin nbits = 32;   fill = low[31];     end
            default: begin nbits = XLEN; fill = low[XLEN-1]; end
        endcase
        // funct3[2] selects the unsigned variants
        fill   = fill & ~funct3_i[2];
        data_o = '0;
        for (int i = 0; i < XLEN; i++)
            data_o[i] = (i < nbits) ? low[i] : fill;
    end

endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: accepts one load, issues one or two aligned memory reads,
// merges and extends the result. Ports: req_* request handshake, mem_* memory
// port, rsp_* one-cycle response with error flag.
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] addr_i,
    input  logic [2:0]      funct3_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            rsp_err_o
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    load_state_e     state;
    logic [XLEN-1:0] base_q;
    logic [XLEN-1:0] word0_q;
    logic [XLEN-1:0] word1_q;
    logic [2:0]      funct3_q;
    logic [OW-1:0]   ofs_q;
    logic            cross_q;

    logic [OW-1:0]   ofs_in;
    logic [3:0]      size_in;
    logic            cross_in;
    logic            misal_in;
    logic            err_in;
    logic [XLEN-1:0] base_in;
    logic [XLEN-1:0] ext_w0;
    logic [XLEN-1:0] ext_w1;
    logic [XLEN-1:0] ext_data;

    assign ofs_in   = addr_i[OW-1:0];
    assign size_in  = load_size(funct3_i);
    assign cross_in = (int'(ofs_in) + int'(size_in)) > NB;
    assign misal_in = (ofs_in & OW'(size_in - 4'd1)) != '0;
    assign err_in   = !load_legal(funct3_i, XLEN) ||
                      (!MISALIGNED_EN && misal_in);
    assign base_in  = {addr_i[XLEN-1:OW], {OW{1'b0}}};

    // Bypass the returning word so the response can be registered on rvalid.
    assign ext_w0 = (state == S_WAIT0) ? mem_rdata_i : word0_q;
    assign ext_w1 = (state == S_WAIT1) ? mem_rdata_i : word1_q;

    load_extract_extend #(.XLEN(XLEN)) u_extract (
        .word0_i  (ext_w0),
        .word1_i  (ext_w1),
        .ofs_i    (ofs_q),
        .funct3_i (funct3_q),
        .data_o   (ext_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            req_ready_o <= 1'b1;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            base_q      <= '0;
            word0_q     <= '0;
            word1_q     <= '0;
            funct3_q    <= '0;
            ofs_q       <= '0;
            cross_q     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        funct3_q    <= funct3_i;
                        ofs_q       <= ofs_in;
                        cross_q     <= cross_in;
                        base_q      <= base_in;
                        word0_q     <= '0;
                        word1_q     <= '0;
                        req_ready_o <= 1'b0;
                        if (err_in) begin
                            state       <= S_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                        end else begin
                            state      <= S_REQ0;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= base_in;
                        end
                    end
                end
                S_REQ0: begin
                    if (mem_gnt_i) begin
                        mem_req_o  <= 1'b0;
                        mem_addr_o <= '0;
                        state      <= S_WAIT0;
                    end
                end
                S_WAIT0: begin
                    if (mem_rvalid_i) begin
                        word0_q <= mem_rdata_i;
                        if (cross_q) begin
                            state      <= S_REQ1;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= base_q + XLEN'(NB);
                        end else begin
                            state       <= S_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_data_o  <= ext_data;
                        end
                    end
                end
                S_REQ1: begin
                    if (mem_gnt_i) begin
                        mem_req_o  <= 1'b0;
                        mem_addr_o <= '0;
                        state      <= S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (mem_rvalid_i) begin
                        word1_q     <= mem_rdata_i;
                        state       <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= ext_data;
                    end
                end
                S_RESP: begin
                    rsp_valid_o <= 1'b0;
                    rsp_data_o  <= '0;
                    rsp_err_o   <= 1'b0;
                    req_ready_o <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed checks of load_align_unit in three builds:
// XLEN=32 split-capable, XLEN=32 misaligned-error, XLEN=64.
module tb_load_align_unit;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // XLEN=32, MISALIGNED_EN=1
    logic        a_valid, a_ready, a_mreq, a_gnt, a_rvalid, a_rsp_valid, a_rsp_err;
    logic [31:0] a_addr, a_maddr, a_rdata, a_rsp_data;
    logic [2:0]  a_f3;
    int          a_nreq = 0;
    int          a_nrsp = 0;

    // XLEN=32, MISALIGNED_EN=0
    logic        b_valid, b_ready, b_mreq, b_gnt, b_rvalid, b_rsp_valid, b_rsp_err;
    logic [31:0] b_addr, b_maddr, b_rdata, b_rsp_data;
    logic [2:0]  b_f3;

    // XLEN=64, MISALIGNED_EN=1
    logic        c_valid, c_ready, c_mreq, c_gnt, c_rvalid, c_rsp_valid, c_rsp_err;
    logic [63:0] c_addr, c_maddr, c_rdata, c_rsp_data;
    logic [2:0]  c_f3;

    load_align_unit #(.XLEN(32), .MISALIGNED_EN(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(a_valid), .req_ready_o(a_ready),
        .addr_i(a_addr), .funct3_i(a_f3), .mem_req_o(a_mreq), .mem_addr_o(a_maddr),
        .mem_gnt_i(a_gnt), .mem_rvalid_i(a_rvalid), .mem_rdata_i(a_rdata),
        .rsp_valid_o(a_rsp_valid), .rsp_data_o(a_rsp_data), .rsp_err_o(a_rsp_err)
    );

    load_align_unit #(.XLEN(32), .MISALIGNED_EN(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(b_valid), .req_ready_o(b_ready),
        .addr_i(b_addr), .funct3_i(b_f3), .mem_req_o(b_mreq), .mem_addr_o(b_maddr),
        .mem_gnt_i(b_gnt), .mem_rvalid_i(b_rvalid), .mem_rdata_i(b_rdata),
        .rsp_valid_o(b_rsp_valid), .rsp_data_o(b_rsp_data), .rsp_err_o(b_rsp_err)
    );

    load_align_unit #(.XLEN(64), .MISALIGNED_EN(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst), .req_valid_i(c_valid), .req_ready_o(c_ready),
        .addr_i(c_addr), .funct3_i(c_f3), .mem_req_o(c_mreq), .mem_addr_o(c_maddr),
        .mem_gnt_i(c_gnt), .mem_rvalid_i(c_rvalid), .mem_rdata_i(c_rdata),
        .rsp_valid_o(c_rsp_valid), .rsp_data_o(c_rsp_data), .rsp_err_o(c_rsp_err)
    );

    always @(posedge clk) begin
        if (a_mreq && a_gnt) a_nreq++;
        if (a_rsp_valid)     a_nrsp++;
    end

    // Memory side for unit A: wait for a request, grant it, return data next cycle.
    task automatic a_serve(input logic [31:0] data, output logic [31:0] seen, output bit tmo);
        tmo  = 1'b1;
        seen = '0;
        for (int i = 0; i < 20 && tmo; i++) begin
            if (a_mreq) tmo = 1'b0;
            else @(negedge clk);
        end
        if (!tmo) begin
            seen  = a_maddr;
            a_gnt = 1'b1;
            @(negedge clk);
            a_gnt = 1'b0; a_rvalid = 1'b1; a_rdata = data;
            @(negedge clk);
            a_rvalid = 1'b0; a_rdata = '0;
        end
    endtask

    task automatic c_serve(input logic [63:0] data, output logic [63:0] seen, output bit tmo);
        tmo  = 1'b1;
        seen = '0;
        for (int i = 0; i < 20 && tmo; i++) begin
            if (c_mreq) tmo = 1'b0;
            else @(negedge clk);
        end
        if (!tmo) begin
            seen  = c_maddr;
            c_gnt = 1'b1;
            @(negedge clk);
            c_gnt = 1'b0; c_rvalid = 1'b1; c_rdata = data;
            @(negedge clk);
            c_rvalid = 1'b0; c_rdata = '0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", a_ready); end
        checks++; if (a_mreq !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", a_mreq); end
        checks++; if (a_maddr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", a_maddr); end
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", a_rsp_valid); end
        checks++; if (a_rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", a_rsp_data); end
        checks++; if (a_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", a_rsp_err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lb_signed;
        logic [31:0] seen;
        bit          tmo;
        int          t0;
        t0 = cyc;
        a_valid = 1'b1; a_addr = 32'h0000_1003; a_f3 = 3'b000;
        @(negedge clk);
        a_valid = 1'b0;
        a_serve(32'h80FF_1234, seen, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL lb_timeout: no mem_req seen"); end
        checks++; if (seen !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr: got %h want 00001000", seen); end
        checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL lb_valid: got %b want 1", a_rsp_valid); end
        checks++; if (a_rsp_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffff80", a_rsp_data); end
        checks++; if (a_rsp_err !== 1'b0) begin errors++; $display("FAIL lb_err: got %b want 0", a_rsp_err); end
        checks++; if (cyc - t0 !== 3) begin errors++; $display("FAIL lb_latency: got %0d want 3", cyc - t0); end
        @(negedge clk);
        checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL lb_pulse: got %b want 0", a_rsp_valid); end
        checks++; if (a_rsp_data !== 32'h0) begin errors++; $display("FAIL lb_data_clear: got %h want 0", a_rsp_data); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL lb_ready: got %b want 1", a_ready); end
    endtask

    task automatic test_lhu_single;
        logic [31:0] seen;
        bit          tmo;
        int          n0;
        n0 = a_nreq;
        a_valid = 1'b1; a_addr = 32'h0000_1002; a_f3 = 3'b101;
        @(negedge clk);
        a_valid = 1'b0;
        a_serve(32'hBEEF_0000, seen, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL lhu_timeout: no mem_req seen"); end
        checks++; if (a_rsp_data !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_data: got %h want 0000beef", a_rsp_data); end
        checks++; if (a_nreq - n0 !== 1) begin errors++; $display("FAIL lhu_nreq: got %0d want 1", a_nreq - n0); end
        checks++; if (a_mreq !== 1'b0) begin errors++; $display("FAIL lhu_no_second: got %b want 0", a_mreq); end
        @(negedge clk);
    endtask

    task automatic test_cross;
        logic [31:0] s0, s1;
        bit          t0o, t1o;
        int          t0, n0;
        t0 = cyc; n0 = a_nreq;
        a_valid = 1'b1; a_addr = 32'h0000_1002; a_f3 = 3'b010;
        @(negedge clk);
        a_valid = 1'b0;
        a_serve(32'h4433_2211, s0, t0o);
        a_serve(32'h8877_6655, s1, t1o);
        checks++; if ({t0o, t1o} !== 2'b00) begin errors++; $display("FAIL cross_timeout: got %b want 00", {t0o, t1o}); end
        checks++; if (s0 !== 32'h0000_1000) begin errors++; $display("FAIL cross_addr0: got %h want 00001000", s0); end
        checks++; if (s1 !== 32'h0000_1004) begin errors++; $display("FAIL cross_addr1: got %h want 00001004", s1); end
        checks++; if (a_rsp_data !== 32'h6655_4433) begin errors++; $display("FAIL cross_data: got %h want 66554433", a_rsp_data); end
        checks++; if (cyc - t0 !== 5) begin errors++; $display("FAIL cross_latency: got %0d want 5", cyc - t0); end
        checks++; if (a_nreq - n0 !== 2) begin errors++; $display("FAIL cross_nreq: got %0d want 2", a_nreq - n0); end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        logic [31:0] s0, s1;
        bit          t0o, t1o;
        a_valid = 1'b1; a_addr = 32'hFFFF_FFFF; a_f3 = 3'b001;
        @(negedge clk);
        a_valid = 1'b0;
        a_serve(32'hAB00_0000, s0, t0o);
        a_serve(32'h0000_00CD, s1, t1o);
        checks++; if (s0 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h want fffffffc", s0); end
        checks++; if (s1 !== 32'h0000_0000 || t1o) begin errors++; $display("FAIL wrap_addr1: got %h want 00000000", s1); end
        checks++; if (a_rsp_data !== 32'hFFFF_CDAB) begin errors++; $display("FAIL wrap_data: got %h want ffffcdab", a_rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_misaligned_ok;
        logic [31:0] seen;
        bit          tmo;
        a_valid = 1'b1; a_addr = 32'h0000_1001; a_f3 = 3'b001;
        @(negedge clk);
        a_valid = 1'b0;
        a_serve(32'h00AB_CD00, seen, tmo);
        checks++; if (a_rsp_err !== 1'b0 || tmo) begin errors++; $display("FAIL mis_ok_err: got err %b tmo %b want 0 0", a_rsp_err, tmo); end
        checks++; if (a_rsp_data !== 32'hFFFF_ABCD) begin errors++; $display("FAIL mis_ok_data: got %h want ffffabcd", a_rsp_data); end
        @(negedge clk);
        a_valid = 1'b1; a_addr = 32'h0000_1000; a_f3 = 3'b011;
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if ({a_rsp_valid, a_rsp_err, a_mreq} !== 3'b110) begin errors++; $display("FAIL ld32_illegal: got v/e/req %b want 110", {a_rsp_valid, a_rsp_err, a_mreq}); end
        @(negedge clk);
    endtask

    task automatic test_gnt_stall;
        logic [31:0] seen;
        bit          tmo;
        a_valid = 1'b1; a_addr = 32'h0000_1004; a_f3 = 3'b010;
        @(negedge clk);
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (a_mreq !== 1'b1 || a_maddr !== 32'h0000_1004) begin errors++; $display("FAIL stall_hold%0d: got req %b addr %h want 1 00001004", i, a_mreq, a_maddr); end
            @(negedge clk);
        end
        a_serve(32'hDEAD_BEEF, seen, tmo);
        checks++; if (seen !== 32'h0000_1004 || tmo) begin errors++; $display("FAIL stall_addr: got %h want 00001004", seen); end
        checks++; if (a_rsp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_data: got %h want deadbeef", a_rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight;
        logic [31:0] seen;
        bit          tmo;
        int          n0;
        a_valid = 1'b1; a_addr = 32'h0000_1002; a_f3 = 3'b010;
        @(negedge clk);
        a_valid = 1'b0;
        a_serve(32'h1111_1111, seen, tmo);
        checks++; if (a_mreq !== 1'b1 || tmo) begin errors++; $display("FAIL rstmid_req1: got %b want 1", a_mreq); end
        a_gnt = 1'b1;
        @(negedge clk);
        a_gnt = 1'b0;
        n0 = a_nrsp;
        rst = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1 || a_mreq !== 1'b0) begin errors++; $display("FAIL rstmid_state: got ready %b req %b want 1 0", a_ready, a_mreq); end
        @(negedge clk);
        rst = 1'b0;
        a_rvalid = 1'b1; a_rdata = 32'h2222_2222;
        @(negedge clk);
        a_rvalid = 1'b0; a_rdata = '0;
        @(negedge clk);
        checks++; if (a_nrsp - n0 !== 0 || a_rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d responses want 0", a_nrsp - n0); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", a_ready); end
    endtask

    task automatic test_err_no_misaligned;
        int t0;
        t0 = cyc;
        b_valid = 1'b1; b_addr = 32'h0000_1001; b_f3 = 3'b001;
        @(negedge clk);
        b_valid = 1'b0;
        checks++; if ({b_rsp_valid, b_rsp_err} !== 2'b11) begin errors++; $display("FAIL mis_err: got v/e %b want 11", {b_rsp_valid, b_rsp_err}); end
        checks++; if (b_rsp_data !== 32'h0) begin errors++; $display("FAIL mis_err_data: got %h want 0", b_rsp_data); end
        checks++; if (b_mreq !== 1'b0) begin errors++; $display("FAIL mis_err_req: got %b want 0", b_mreq); end
        checks++; if (cyc - t0 !== 1) begin errors++; $display("FAIL mis_err_latency: got %0d want 1", cyc - t0); end
        @(negedge clk);
        checks++; if ({b_rsp_valid, b_rsp_err, b_ready} !== 3'b001) begin errors++; $display("FAIL mis_err_after: got v/e/rdy %b want 001", {b_rsp_valid, b_rsp_err, b_ready}); end
        b_valid = 1'b1; b_addr = 32'h0000_1000; b_f3 = 3'b111;
        @(negedge clk);
        b_valid = 1'b0;
        checks++; if ({b_rsp_valid, b_rsp_err, b_mreq} !== 3'b110 || b_rsp_data !== 32'h0) begin errors++; $display("FAIL f3_111: got v/e/req %b data %h want 110 0", {b_rsp_valid, b_rsp_err, b_mreq}, b_rsp_data); end
        @(negedge clk);
        b_valid = 1'b1; b_addr = 32'h0000_1002; b_f3 = 3'b101;
        @(negedge clk);
        b_valid = 1'b0;
        checks++; if (b_mreq !== 1'b1 || b_rsp_valid !== 1'b0) begin errors++; $display("FAIL aligned_noerr_req: got req %b v %b want 1 0", b_mreq, b_rsp_valid); end
        b_gnt = 1'b1;
        @(negedge clk);
        b_gnt = 1'b0; b_rvalid = 1'b1; b_rdata = 32'h1234_5678;
        @(negedge clk);
        b_rvalid = 1'b0;
        checks++; if (b_rsp_data !== 32'h0000_1234 || b_rsp_err !== 1'b0) begin errors++; $display("FAIL aligned_noerr_data: got %h err %b want 00001234 0", b_rsp_data, b_rsp_err); end
        @(negedge clk);
    endtask

    task automatic test_xlen64;
        logic [63:0] seen;
        bit          tmo;
        c_valid = 1'b1; c_addr = 64'h2004; c_f3 = 3'b110;
        @(negedge clk);
        c_valid = 1'b0;
        c_serve(64'hFFFF_FFFF_0000_0000, seen, tmo);
        checks++; if (seen !== 64'h2000 || tmo) begin errors++; $display("FAIL x64_addr: got %h want 2000", seen); end
        checks++; if (c_rsp_data !== 64'h0000_0000_FFFF_FFFF || c_rsp_err !== 1'b0) begin errors++; $display("FAIL x64_lwu: got %h want 00000000ffffffff", c_rsp_data); end
        @(negedge clk);
        c_valid = 1'b1; c_addr = 64'h2004; c_f3 = 3'b010;
        @(negedge clk);
        c_valid = 1'b0;
        c_serve(64'hFFFF_FFFF_0000_0000, seen, tmo);
        checks++; if (c_rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL x64_lw: got %h want ffffffffffffffff", c_rsp_data); end
        @(negedge clk);
        c_valid = 1'b1; c_addr = 64'h2000; c_f3 = 3'b011;
        @(negedge clk);
        c_valid = 1'b0;
        c_serve(64'hFFFF_FFFF_0000_0000, seen, tmo);
        checks++; if (c_rsp_data !== 64'hFFFF_FFFF_0000_0000 || c_rsp_err !== 1'b0) begin errors++; $display("FAIL x64_ld: got %h want ffffffff00000000", c_rsp_data); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_f3 = '0; a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = '0;
        b_valid = 1'b0; b_addr = '0; b_f3 = '0; b_gnt = 1'b0; b_rvalid = 1'b0; b_rdata = '0;
        c_valid = 1'b0; c_addr = '0; c_f3 = '0; c_gnt = 1'b0; c_rvalid = 1'b0; c_rdata = '0;
        test_reset();
        test_lb_signed();
        test_lhu_single();
        test_cross();
        test_wrap();
        test_misaligned_ok();
        test_gnt_stall();
        test_reset_midflight();
        test_err_no_misaligned();
        test_xlen64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised load data path between the LSU address stage and the data-memory port.
- Accepts one load per handshake and issues one aligned memory word request.
- If the access crosses a word boundary, it issues a second request.
- Merges the returned words, extracts the addressed bytes, and sign- or zero-extends them per funct3 to XLEN.
- Replaces the single-cycle RV32-only combinational load extender.

Parameters:
- XLEN, 32, datapath and bus width in bits; 32 or 64.
- MISALIGNED_EN, 1, 1 = split boundary-crossing loads into two accesses; 0 = any non-naturally-aligned load returns an error.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- req_valid_i  input  1  load request valid
- req_ready_o  output  1  unit can accept a request
- addr_i  input  XLEN  byte address
- funct3_i  input  3  load funct3
- mem_req_o  output  1  memory request
- mem_addr_o  output  XLEN  word-aligned memory address
- mem_gnt_i  input  1  memory accepted the request
- mem_rvalid_i  input  1  memory read data valid
- mem_rdata_i  input  XLEN  memory read word
- rsp_valid_o  output  1  result valid, one-cycle pulse
- rsp_data_o  output  XLEN  extended load result
- rsp_err_o  output  1  illegal funct3, or misaligned access with MISALIGNED_EN=0

Behaviour:
- Definitions:
  - NB = XLEN/8; OFS = addr[log2(NB)-1:0].
  - Size by funct3: 000/100 = 1 byte, 001/101 = 2 bytes, 010/110 = 4 bytes, 011 = 8 bytes.
  - Legal funct3: 000, 001, 010, 100, 101. With XLEN=64, 011 (LD) and 110 (LWU) are also legal. Everything else is illegal.
  - Sign-extend for 000/001/010/011; zero-extend for 100/101/110.
  - CROSS = OFS + size > NB. MISAL = OFS mod size != 0.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - req_ready_o=1. On req_valid_i, latch addr, funct3, OFS and CROSS.
  - Illegal funct3, or MISAL with MISALIGNED_EN=0 → RESP with err=1; no memory access.
  - Otherwise → REQ0.
- REQ0:
  - mem_req_o=1, mem_addr_o = addr with low log2(NB) bits cleared.
  - Address held stable until mem_gnt_i, then → WAIT0.
- WAIT0:
  - On mem_rvalid_i, capture word0.
  - CROSS → REQ1; else → RESP.
- REQ1: as REQ0, with address = aligned addr + NB (wraps modulo 2^XLEN). On gnt → WAIT1.
- WAIT1: on mem_rvalid_i, capture word1 → RESP.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, then → IDLE.
  - rsp_data_o = extend({word1, word0} >> 8*OFS, size).
  - On error: rsp_data_o=0, rsp_err_o=1.
  - rsp_data_o and rsp_err_o are zero whenever rsp_valid_o=0.
- Handshake rules:
  - req_ready_o is high only in IDLE. Requests are not accepted in RESP; there is no back-to-back overlap.
  - mem_rvalid_i outside WAIT0/WAIT1 is ignored.
  - A gnt and rvalid in the same cycle is not supported; the memory returns rvalid at least one cycle after gnt.
- Latency (gnt same cycle as request, rvalid one cycle later), counted from acceptance:
  - Aligned load: rsp_valid_o 3 cycles after acceptance.
  - Crossing load: 5 cycles.
  - Error: 1 cycle.
- Reset:
  - Value: state=IDLE, req_ready_o=1, mem_req_o=0, mem_addr_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, captured words=0.
  - Asserted mid-operation: the in-flight load is dropped with no response. Any late rvalid is ignored.

Decomposition:
- definitions_pkg:
  - load_funct3_e enum (LB, LH, LW, LD, LBU, LHU, LWU).
  - load_state_e.
  - Helper function load_size(funct3).
- One combinational sub-module: load_extract_extend, parametrised by XLEN, performing the shift, byte select and extension. Unit-testable alone.

Test Plan:
- XLEN=32, LB @0x1003, mem word 0x80FF_1234 → mem_addr_o=0x1000, rsp_data_o=0xFFFF_FF80, rsp_valid_o 3 cycles after accept.
- LHU @0x1002, word 0xBEEF_0000 → rsp_data_o=0x0000_BEEF, one memory request only.
- LW @0x1002, word 0x4433_2211 @0x1000, word 0x8877_6655 @0x1004 → requests to 0x1000 then 0x1004, rsp_data_o=0x6655_4433, latency 5.
- MISALIGNED_EN=0, LH @0x1001 → no mem_req_o, rsp_valid_o next cycle with rsp_err_o=1, rsp_data_o=0. funct3=111 → same error response.
- mem_gnt_i withheld 3 cycles → mem_req_o/mem_addr_o stable. rst_i pulsed in WAIT1 → no rsp_valid_o, req_ready_o=1, subsequent rvalid ignored.
- XLEN=64, word 0xFFFF_FFFF_0000_0000 @0x2000: LWU @0x2004 → 0x0000_0000_FFFF_FFFF; LW @0x2004 → 0xFFFF_FFFF_FFFF_FFFF; LD @0x2000 → full word.
